// File: rtl/commit_pc_streamer.sv
`timescale 1ns/1ps
// commit_pc_streamer
//
// Buffers retired PCs from the core in a FIFO and streams them, one at a
// time, to the co-simulation PC checker over a valid/ready handshake. The
// checker's verdict for each transfer is counted; once MAX_MISS mismatches
// have been seen the stream freezes in HALT until reset.
//
// Optional feature macro: STREAM_TIMEOUT_EN
//   When defined, a response that does not arrive within TIMEOUT cycles of
//   acceptance is treated as a miss with expected PC all-ones and sets
//   timeout_err. When undefined, the block waits indefinitely for a response
//   and timeout_err is tied to 0.
//
// Ports:
//   clk, rst_n      clock (posedge) and synchronous active-low reset
//   ret_valid       core retired one instruction this cycle
//   ret_pc          PC of the retired instruction
//   ret_ready       FIFO can accept a retire (registered state only)
//   chk_valid       chk_pc is presented to the checker
//   chk_pc          head-of-FIFO PC (0 when not presenting)
//   chk_ready       checker accepts chk_pc
//   chk_resp_valid  checker verdict valid
//   chk_miss        verdict: 1 = mismatch
//   chk_npc         checker's expected PC for the transfer
//   halted          sticky, stream frozen
//   miss_count      saturating mismatch count
//   first_miss_pc   sent PC of the first miss
//   first_miss_exp  expected PC reported with the first miss
//   occupancy       FIFO fill level
//   proto_err       sticky, response seen while no transfer outstanding
//   timeout_err     sticky, response timeout (STREAM_TIMEOUT_EN only)
module commit_pc_streamer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MAX_MISS = 1,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ret_valid,
  input  logic [63:0]              ret_pc,
  output logic                     ret_ready,
  output logic                     chk_valid,
  output logic [63:0]              chk_pc,
  input  logic                     chk_ready,
  input  logic                     chk_resp_valid,
  input  logic                     chk_miss,
  input  logic [63:0]              chk_npc,
  output logic                     halted,
  output logic [15:0]              miss_count,
  output logic [63:0]              first_miss_pc,
  output logic [63:0]              first_miss_exp,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     proto_err,
  output logic                     timeout_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_HALT
  } state_t;

  state_t          state_q, state_d;

  logic [63:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            alive_q;
  logic [63:0]     sent_pc_q;
  logic [15:0]     miss_count_q;
  logic [63:0]     first_miss_pc_q, first_miss_exp_q;
  logic            proto_err_q;

  logic            full;
  logic            push, pop;
  logic            verdict, verdict_miss;
  logic [63:0]     verdict_npc;
  logic            proto_hit;

`ifdef STREAM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   wait_cnt_q;
  logic            timeout_fire;
  logic            timeout_err_q;
`endif

  // alive_q keeps ret_ready low during reset and rises on the first clock
  // after release, so ret_ready never depends on rst_n combinationally.
  assign full      = (count_q == CW'(DEPTH));
  assign ret_ready = alive_q && !full && (state_q != S_HALT);
  assign push      = ret_valid && ret_ready;
  assign pop       = (state_q == S_SEND) && chk_ready;

  assign chk_valid      = (state_q == S_SEND);
  assign chk_pc         = (state_q == S_SEND) ? mem[rd_ptr_q] : '0;
  assign halted         = (state_q == S_HALT);
  assign miss_count     = miss_count_q;
  assign first_miss_pc  = first_miss_pc_q;
  assign first_miss_exp = first_miss_exp_q;
  assign occupancy      = count_q;
  assign proto_err      = proto_err_q;

`ifdef STREAM_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    verdict      = 1'b0;
    verdict_miss = 1'b0;
    verdict_npc  = chk_npc;
    proto_hit    = 1'b0;
`ifdef STREAM_TIMEOUT_EN
    timeout_fire = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        proto_hit = chk_resp_valid;
        if (count_q != '0) state_d = S_SEND;
      end
      S_SEND: begin
        proto_hit = chk_resp_valid;
        if (chk_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (chk_resp_valid) begin
          verdict      = 1'b1;
          verdict_miss = chk_miss;
        end
`ifdef STREAM_TIMEOUT_EN
        else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
          verdict      = 1'b1;
          verdict_miss = 1'b1;
          verdict_npc  = '1;
          timeout_fire = 1'b1;
        end
`endif
        if (verdict) begin
          // count_q already excludes the entry popped on entry to WAIT
          if (verdict_miss && (({1'b0, miss_count_q} + 17'd1) >= 17'(MAX_MISS)))
            state_d = S_HALT;
          else if (count_q != '0)
            state_d = S_SEND;
          else
            state_d = S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage has no reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= ret_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      alive_q          <= 1'b0;
      sent_pc_q        <= '0;
      miss_count_q     <= '0;
      first_miss_pc_q  <= '0;
      first_miss_exp_q <= '0;
      proto_err_q      <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      state_q <= state_d;

      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        sent_pc_q <= mem[rd_ptr_q];
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (verdict && verdict_miss) begin
        if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
        // The count saturates and never returns to 0, so this is the first miss.
        if (miss_count_q == '0) begin
          first_miss_pc_q  <= sent_pc_q;
          first_miss_exp_q <= verdict_npc;
        end
      end

      if (proto_hit) proto_err_q <= 1'b1;
    end
  end

`ifdef STREAM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      // Restarts on every entry to WAIT, since WAIT is always entered from SEND.
      if (state_q != S_WAIT) wait_cnt_q <= '0;
      else                   wait_cnt_q <= wait_cnt_q + TW'(1);
      if (timeout_fire) timeout_err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_pc_streamer.sv
`timescale 1ns/1ps
module tb_commit_pc_streamer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 16;
  localparam int unsigned OW    = $clog2(DEPTH) + 1;

  logic clk, rst_n, ret_valid, chk_ready, chk_resp_valid, chk_miss;
  logic [63:0] ret_pc, chk_npc;

  logic a_ret_ready, a_chk_valid, a_halted, a_proto_err, a_timeout_err;
  logic [63:0] a_chk_pc, a_first_miss_pc, a_first_miss_exp;
  logic [15:0] a_miss_count;
  logic [OW-1:0] a_occupancy;

  logic b_ret_ready, b_chk_valid, b_halted, b_proto_err, b_timeout_err;
  logic [63:0] b_chk_pc, b_first_miss_pc, b_first_miss_exp;
  logic [15:0] b_miss_count;
  logic [OW-1:0] b_occupancy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  commit_pc_streamer #(.DEPTH(DEPTH), .MAX_MISS(1), .TIMEOUT(TMO)) u_a (
    .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_ready(a_ret_ready), .chk_valid(a_chk_valid), .chk_pc(a_chk_pc),
    .chk_ready(chk_ready), .chk_resp_valid(chk_resp_valid), .chk_miss(chk_miss),
    .chk_npc(chk_npc), .halted(a_halted), .miss_count(a_miss_count),
    .first_miss_pc(a_first_miss_pc), .first_miss_exp(a_first_miss_exp),
    .occupancy(a_occupancy), .proto_err(a_proto_err), .timeout_err(a_timeout_err)
  );

  commit_pc_streamer #(.DEPTH(DEPTH), .MAX_MISS(3), .TIMEOUT(TMO)) u_b (
    .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_ready(b_ret_ready), .chk_valid(b_chk_valid), .chk_pc(b_chk_pc),
    .chk_ready(chk_ready), .chk_resp_valid(chk_resp_valid), .chk_miss(chk_miss),
    .chk_npc(chk_npc), .halted(b_halted), .miss_count(b_miss_count),
    .first_miss_pc(b_first_miss_pc), .first_miss_exp(b_first_miss_exp),
    .occupancy(b_occupancy), .proto_err(b_proto_err), .timeout_err(b_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ret_valid = 1'b0; ret_pc = '0; chk_ready = 1'b0;
    chk_resp_valid = 1'b0; chk_miss = 1'b0; chk_npc = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    cyc(); cyc();
    n_checks++;
    if ({a_ret_ready, a_chk_valid, a_halted, a_proto_err, a_timeout_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {a_ret_ready, a_chk_valid, a_halted, a_proto_err, a_timeout_err});
    end
    n_checks++;
    if (a_chk_pc !== 64'd0 || a_first_miss_pc !== 64'd0 || a_first_miss_exp !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_pcs: got %h/%h/%h expected all 0", a_chk_pc, a_first_miss_pc, a_first_miss_exp);
    end
    n_checks++;
    if (a_miss_count !== 16'd0 || a_occupancy !== '0) begin
      n_fail++;
      $display("FAIL reset_counts: got miss %0d occ %0d expected 0/0", a_miss_count, a_occupancy);
    end
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if (a_ret_ready !== 1'b1 || b_ret_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: got %b%b expected 11", a_ret_ready, b_ret_ready);
    end
    exp_q.delete();
  endtask

  // Three back-to-back retires streamed to a checker that always hits.
  task automatic test_stream_hits();
    logic [63:0] pcs [3];
    int idx = 0, got = 0;
    logic hs, resp_pending = 1'b0;
    pcs[0] = 64'h1000; pcs[1] = 64'h1004; pcs[2] = 64'h1008;
    reset_dut();
    chk_ready = 1'b1;
    for (int c = 0; c < 60 && got < 3; c++) begin
      if (idx < 3) begin
        ret_valid = 1'b1; ret_pc = pcs[idx]; exp_q.push_back(pcs[idx]); idx++;
      end else ret_valid = 1'b0;
      hs = a_chk_valid && chk_ready;
      if (hs) begin
        n_checks++;
        if (exp_q.size() == 0 || a_chk_pc !== exp_q[0]) begin
          n_fail++;
          $display("FAIL hits_chk_pc: got %h expected %h", a_chk_pc, (exp_q.size() != 0) ? exp_q[0] : 64'hX);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      chk_resp_valid = resp_pending; chk_miss = 1'b0; chk_npc = '0;
      resp_pending = hs;
      cyc();
    end
    ret_valid = 1'b0;
    chk_resp_valid = resp_pending;
    cyc();
    chk_resp_valid = 1'b0;
    cyc();
    n_checks++;
    if (got != 3) begin n_fail++; $display("FAIL hits_transfers: got %0d expected 3", got); end
    n_checks++;
    if (a_miss_count !== 16'd0 || a_halted !== 1'b0 || a_occupancy !== '0) begin
      n_fail++;
      $display("FAIL hits_final: got miss %0d halt %b occ %0d expected 0/0/0", a_miss_count, a_halted, a_occupancy);
    end
    n_checks++;
    if (a_proto_err !== 1'b0 || a_timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL hits_errs: got proto %b tmo %b expected 0/0", a_proto_err, a_timeout_err);
    end
  endtask

  // Fill to DEPTH with the checker stalled, then drain in order.
  task automatic test_full_backpressure();
    int got = 0;
    logic hs, resp_pending = 1'b0;
    reset_dut();
    chk_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (a_ret_ready !== ((i < 8) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL full_ret_ready_%0d: got %b expected %b", i, a_ret_ready, (i < 8));
      end
      ret_valid = 1'b1; ret_pc = 64'h3000 + 64'(4 * i);
      if (i < 8) exp_q.push_back(ret_pc);
      cyc();
      if (i == 0) begin
        n_checks++;
        if (a_chk_valid !== 1'b0) begin n_fail++; $display("FAIL latency_1: got %b expected 0", a_chk_valid); end
      end
      if (i == 1) begin
        n_checks++;
        if (a_chk_valid !== 1'b1) begin n_fail++; $display("FAIL latency_2: got %b expected 1", a_chk_valid); end
      end
    end
    ret_valid = 1'b0;
    cyc();
    n_checks++;
    if (a_occupancy !== OW'(8) || a_ret_ready !== 1'b0 || a_chk_pc !== 64'h3000) begin
      n_fail++;
      $display("FAIL full_state: got occ %0d ready %b pc %h expected 8/0/3000", a_occupancy, a_ret_ready, a_chk_pc);
    end
    chk_ready = 1'b1;
    for (int c = 0; c < 100 && got < 8; c++) begin
      hs = a_chk_valid && chk_ready;
      if (hs) begin
        n_checks++;
        if (exp_q.size() == 0 || a_chk_pc !== exp_q[0]) begin
          n_fail++;
          $display("FAIL drain_chk_pc: got %h expected %h", a_chk_pc, (exp_q.size() != 0) ? exp_q[0] : 64'hX);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      chk_resp_valid = resp_pending; chk_miss = 1'b0;
      resp_pending = hs;
      cyc();
    end
    chk_resp_valid = resp_pending;
    cyc();
    chk_resp_valid = 1'b0;
    cyc();
    n_checks++;
    if (got != 8 || a_occupancy !== '0 || a_ret_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_final: got n %0d occ %0d ready %b expected 8/0/1", got, a_occupancy, a_ret_ready);
    end
  endtask

  // Single miss halts the MAX_MISS=1 instance; the MAX_MISS=3 one keeps going.
  task automatic test_halt_first_miss();
    int got = 0;
    reset_dut();
    chk_ready = 1'b1;
    ret_valid = 1'b1; ret_pc = 64'h2000; exp_q.push_back(64'h2000);
    cyc();
    ret_valid = 1'b0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      if (a_chk_valid) begin
        n_checks++;
        if (a_chk_pc !== exp_q[0]) begin n_fail++; $display("FAIL halt_chk_pc: got %h expected %h", a_chk_pc, exp_q[0]); end
        void'(exp_q.pop_front());
        got++;
      end
      cyc();
    end
    n_checks++;
    if (got != 1) begin n_fail++; $display("FAIL halt_transfer: got %0d expected 1", got); end
    chk_resp_valid = 1'b1; chk_miss = 1'b1; chk_npc = 64'h2004;
    cyc();
    chk_resp_valid = 1'b0; chk_miss = 1'b0;
    n_checks++;
    if (a_halted !== 1'b1 || a_miss_count !== 16'd1 || a_ret_ready !== 1'b0 || a_chk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_state: got halt %b miss %0d ready %b valid %b expected 1/1/0/0",
               a_halted, a_miss_count, a_ret_ready, a_chk_valid);
    end
    n_checks++;
    if (a_first_miss_pc !== 64'h2000 || a_first_miss_exp !== 64'h2004) begin
      n_fail++;
      $display("FAIL halt_capture: got %h/%h expected 2000/2004", a_first_miss_pc, a_first_miss_exp);
    end
    n_checks++;
    if (b_halted !== 1'b0 || b_miss_count !== 16'd1) begin
      n_fail++;
      $display("FAIL halt_b_running: got halt %b miss %0d expected 0/1", b_halted, b_miss_count);
    end
    ret_valid = 1'b1; ret_pc = 64'h2008;
    cyc(); cyc();
    ret_valid = 1'b0;
    cyc();
    n_checks++;
    if (a_chk_valid !== 1'b0 || a_occupancy !== '0 || a_halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_frozen: got valid %b occ %0d halt %b expected 0/0/1", a_chk_valid, a_occupancy, a_halted);
    end
  endtask

  // MAX_MISS=3: miss, hit, miss, miss halts on the fourth response.
  task automatic test_multi_miss();
    logic pat [4];
    int idx = 0, got = 0, k = 0;
    logic hs, was_resp, resp_pending = 1'b0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
    reset_dut();
    chk_ready = 1'b1;
    for (int c = 0; c < 100 && k < 4; c++) begin
      if (idx < 4) begin
        ret_valid = 1'b1; ret_pc = 64'h4000 + 64'(4 * idx); exp_q.push_back(ret_pc); idx++;
      end else ret_valid = 1'b0;
      hs = b_chk_valid && chk_ready;
      if (hs) begin
        n_checks++;
        if (exp_q.size() == 0 || b_chk_pc !== exp_q[0]) begin
          n_fail++;
          $display("FAIL multi_chk_pc: got %h expected %h", b_chk_pc, (exp_q.size() != 0) ? exp_q[0] : 64'hX);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      chk_resp_valid = resp_pending;
      chk_miss = resp_pending ? pat[k] : 1'b0;
      chk_npc = 64'h5000 + 64'(k);
      was_resp = resp_pending;
      resp_pending = hs;
      cyc();
      if (was_resp) begin
        n_checks++;
        if (b_halted !== ((k == 3) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL multi_halt_after_%0d: got %b expected %b", k, b_halted, (k == 3));
        end
        k++;
      end
    end
    ret_valid = 1'b0; chk_resp_valid = 1'b0; chk_miss = 1'b0;
    n_checks++;
    if (k != 4) begin n_fail++; $display("FAIL multi_responses: got %0d expected 4", k); end
    n_checks++;
    if (b_miss_count !== 16'd3 || b_first_miss_pc !== 64'h4000 || b_first_miss_exp !== 64'h5000) begin
      n_fail++;
      $display("FAIL multi_final: got miss %0d pc %h exp %h expected 3/4000/5000",
               b_miss_count, b_first_miss_pc, b_first_miss_exp);
    end
  endtask

  // Stray response in IDLE, then reset while a transfer is outstanding.
  task automatic test_proto_and_reset();
    int got = 0;
    reset_dut();
    chk_resp_valid = 1'b1; chk_miss = 1'b1; chk_npc = 64'h1234;
    cyc();
    chk_resp_valid = 1'b0; chk_miss = 1'b0;
    n_checks++;
    if (a_proto_err !== 1'b1 || a_miss_count !== 16'd0 || a_halted !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_idle: got proto %b miss %0d halt %b expected 1/0/0", a_proto_err, a_miss_count, a_halted);
    end
    chk_ready = 1'b1;
    ret_valid = 1'b1; ret_pc = 64'h6000;
    cyc();
    ret_pc = 64'h6004;
    cyc();
    ret_valid = 1'b0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      if (a_chk_valid) got++;
      cyc();
    end
    n_checks++;
    if (got != 1 || a_occupancy !== OW'(1) || a_chk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midwait_setup: got n %0d occ %0d valid %b expected 1/1/0", got, a_occupancy, a_chk_valid);
    end
    chk_ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    n_checks++;
    if ({a_ret_ready, a_chk_valid, a_halted, a_proto_err, a_timeout_err} !== 5'b0 ||
        a_occupancy !== '0 || a_miss_count !== 16'd0 || a_chk_pc !== 64'd0) begin
      n_fail++;
      $display("FAIL midwait_reset: got flags %b occ %0d miss %0d pc %h expected 0",
               {a_ret_ready, a_chk_valid, a_halted, a_proto_err, a_timeout_err}, a_occupancy, a_miss_count, a_chk_pc);
    end
    rst_n = 1'b1;
    cyc(); cyc(); cyc();
    n_checks++;
    if (a_chk_valid !== 1'b0 || a_occupancy !== '0 || a_ret_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_idle: got valid %b occ %0d ready %b expected 0/0/1", a_chk_valid, a_occupancy, a_ret_ready);
    end
  endtask

  task automatic test_timeout();
    int got = 0;
    reset_dut();
    chk_ready = 1'b1;
    ret_valid = 1'b1; ret_pc = 64'h7000;
    cyc();
    ret_valid = 1'b0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      if (a_chk_valid) got++;
      cyc();
    end
    chk_ready = 1'b0;
    n_checks++;
    if (got != 1) begin n_fail++; $display("FAIL tmo_transfer: got %0d expected 1", got); end
`ifdef STREAM_TIMEOUT_EN
    for (int i = 0; i < 15; i++) cyc();
    n_checks++;
    if (a_timeout_err !== 1'b0 || a_halted !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_early: got tmo %b halt %b expected 0/0", a_timeout_err, a_halted);
    end
    cyc();
    n_checks++;
    if (a_timeout_err !== 1'b1 || a_halted !== 1'b1 || a_miss_count !== 16'd1) begin
      n_fail++;
      $display("FAIL tmo_fire: got tmo %b halt %b miss %0d expected 1/1/1", a_timeout_err, a_halted, a_miss_count);
    end
    n_checks++;
    if (a_first_miss_exp !== 64'hFFFF_FFFF_FFFF_FFFF || a_first_miss_pc !== 64'h7000) begin
      n_fail++;
      $display("FAIL tmo_capture: got pc %h exp %h expected 7000/ffffffffffffffff", a_first_miss_pc, a_first_miss_exp);
    end
    chk_resp_valid = 1'b1; chk_miss = 1'b0;
    cyc();
    chk_resp_valid = 1'b0;
    n_checks++;
    if (a_proto_err !== 1'b0 || b_proto_err !== 1'b1 || b_halted !== 1'b0 || b_timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_late_resp: got a_proto %b b_proto %b b_halt %b b_tmo %b expected 0/1/0/1",
               a_proto_err, b_proto_err, b_halted, b_timeout_err);
    end
`else
    for (int i = 0; i < 40; i++) cyc();
    n_checks++;
    if (a_timeout_err !== 1'b0 || a_halted !== 1'b0 || a_miss_count !== 16'd0) begin
      n_fail++;
      $display("FAIL no_tmo_wait: got tmo %b halt %b miss %0d expected 0/0/0", a_timeout_err, a_halted, a_miss_count);
    end
    chk_resp_valid = 1'b1; chk_miss = 1'b0;
    cyc();
    chk_resp_valid = 1'b0;
    cyc();
    n_checks++;
    if (a_proto_err !== 1'b0 || a_halted !== 1'b0 || a_occupancy !== '0) begin
      n_fail++;
      $display("FAIL no_tmo_resp: got proto %b halt %b occ %0d expected 0/0/0", a_proto_err, a_halted, a_occupancy);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_stream_hits();
    test_full_backpressure();
    test_halt_first_miss();
    test_multi_miss();
    test_proto_and_reset();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
